// File: rtl/ddr3_line_requester_if.sv
// Request/response and memory-side signal bundle for ddr3_line_requester.
// master = the requester's view, slave = the client/memory environment's view.
interface ddr3_line_requester_if #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned IO_W   = 512,
  parameter int unsigned MSK_W  = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [MSK_W-1:0]  req_mask;
  logic [IO_W-1:0]   req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [IO_W-1:0]   rsp_rdata;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [MSK_W-1:0]  mem_mask;
  logic [IO_W-1:0]   mem_din;
  logic              mem_we;
  logic [IO_W-1:0]   mem_dout;
  logic              mem_rdy;
  logic              mem_w_rdy;
  logic              mem_init_done;

  modport master (
    input  req_valid, req_we, req_addr, req_mask, req_wdata,
    input  mem_dout, mem_rdy, mem_w_rdy, mem_init_done,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, busy,
    output mem_addr, mem_mask, mem_din, mem_we
  );

  modport slave (
    output req_valid, req_we, req_addr, req_mask, req_wdata,
    output mem_dout, mem_rdy, mem_w_rdy, mem_init_done,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, busy,
    input  mem_addr, mem_mask, mem_din, mem_we
  );
endinterface

// File: rtl/ddr3_line_requester.sv
// One-at-a-time 64-byte line read / masked write initiator for the
// DDR3-substitute line interface. A separator address (addr ^ 1) is driven
// before every task so the memory always sees an address change and restarts.
module ddr3_line_requester #(
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned IO_W    = 512,
  parameter int unsigned MSK_W   = 64,
  parameter int unsigned GAP_MIN = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  reset,
  ddr3_line_requester_if.master bus
);

  localparam int unsigned GAP_W = (GAP_MIN > 1) ? $clog2(GAP_MIN) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_MIN - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_GAP, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic              lat_we_q, lat_we_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [MSK_W-1:0]  lat_mask_q, lat_mask_d;
  logic [IO_W-1:0]   lat_wdata_q, lat_wdata_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [IO_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [MSK_W-1:0]  mem_mask_q, mem_mask_d;
  logic [IO_W-1:0]   mem_din_q, mem_din_d;
  logic              mem_we_q, mem_we_d;
  logic              done;

  // Next-state and next-output computation for the task sequencer.
  always_comb begin
    state_d     = state_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_mask_d  = lat_mask_q;
    lat_wdata_d = lat_wdata_q;
    gap_cnt_d   = gap_cnt_q;
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_mask_d  = mem_mask_q;
    mem_din_d   = mem_din_q;
    mem_we_d    = mem_we_q;
    done        = 1'b0;

    unique case (state_q)
      S_INIT: begin
        mem_we_d   = 1'b0;
        mem_mask_d = '0;
        if (bus.mem_init_done) state_d = S_IDLE;
      end
      S_IDLE: begin
        mem_we_d   = 1'b0;
        mem_mask_d = '0;
        if (bus.req_valid && req_ready_q) begin
          lat_we_d    = bus.req_we;
          lat_addr_d  = bus.req_addr;
          lat_mask_d  = bus.req_mask;
          lat_wdata_d = bus.req_wdata;
          mem_addr_d  = bus.req_addr ^ ADDR_W'(1);
          gap_cnt_d   = '0;
          state_d     = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q >= GAP_LAST && !bus.mem_rdy && !bus.mem_w_rdy) begin
          cnt_d      = '0;
          mem_addr_d = lat_addr_q;
          mem_we_d   = lat_we_q;
          mem_mask_d = lat_we_q ? lat_mask_q : '0;
          mem_din_d  = lat_wdata_q;
          state_d    = S_WAIT;
        end else if (gap_cnt_q < GAP_LAST) begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        // Only the flag matching the task direction counts; completion beats timeout.
        done = lat_we_q ? bus.mem_w_rdy : bus.mem_rdy;
        if (done) begin
          if (!lat_we_q) rsp_rdata_d = bus.mem_dout;
          rsp_err_d  = 1'b0;
          mem_we_d   = 1'b0;
          mem_mask_d = '0;
          state_d    = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_err_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_mask_d = '0;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = bus.mem_init_done ? S_IDLE : S_INIT;
      end
      default: state_d = S_INIT;
    endcase

    // Status outputs are registered copies of what the next state implies.
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  // State and registered outputs; reset drops any in-flight task.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_INIT;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_mask_q  <= '0;
      lat_wdata_q <= '0;
      gap_cnt_q   <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b1;
      mem_addr_q  <= '0;
      mem_mask_q  <= '0;
      mem_din_q   <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_mask_q  <= lat_mask_d;
      lat_wdata_q <= lat_wdata_d;
      gap_cnt_q   <= gap_cnt_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      busy_q      <= busy_d;
      mem_addr_q  <= mem_addr_d;
      mem_mask_q  <= mem_mask_d;
      mem_din_q   <= mem_din_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.busy      = busy_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_mask  = mem_mask_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.mem_we    = mem_we_q;

endmodule

// File: tb/tb_ddr3_line_requester.sv
// Bench for ddr3_line_requester: a 17-cycle line memory responder plus a
// write-history reference model of memory contents.
module tb_ddr3_line_requester;

  localparam int unsigned TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ddr3_line_requester_if #(.ADDR_W(18), .IO_W(512), .MSK_W(64)) bus ();

  ddr3_line_requester #(
    .ADDR_W(18), .IO_W(512), .MSK_W(64), .GAP_MIN(2), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // ---------------- memory responder ----------------
  logic [7:0]   rmem     [262144];
  bit           rwritten [262144];
  logic [17:0]  prev_addr = '0;
  int unsigned  rcnt = 0;
  logic         rdy_r = 1'b0;
  logic [511:0] dout_r = '0;
  logic         kill_rdy = 1'b0;

  function automatic logic [7:0] byte_at(input logic [17:0] a);
    return rwritten[a] ? rmem[a] : a[7:0];
  endfunction

  always @(posedge clk) begin
    if (bus.mem_addr != prev_addr) begin
      rcnt  <= 0;
      rdy_r <= 1'b0;
    end else begin
      if (rcnt == 16 && bus.mem_we)
        for (int k = 0; k < 64; k++)
          if (bus.mem_mask[k]) begin
            rmem[bus.mem_addr + 18'(k)]     <= bus.mem_din[8*k +: 8];
            rwritten[bus.mem_addr + 18'(k)] <= 1'b1;
          end
      if (rcnt >= 16) rdy_r <= 1'b1;
      if (rcnt < 17) rcnt <= rcnt + 1;
    end
    prev_addr <= bus.mem_addr;
    for (int k = 0; k < 64; k++) dout_r[8*k +: 8] <= byte_at(bus.mem_addr + 18'(k));
  end

  assign bus.mem_dout  = dout_r;
  assign bus.mem_rdy   = rdy_r && !kill_rdy;
  assign bus.mem_w_rdy = rdy_r;

  // ---------------- reference model: history of completed writes ----------------
  typedef struct {
    logic [17:0]  a;
    logic [63:0]  m;
    logic [511:0] d;
  } wr_t;
  wr_t wq[$];

  function automatic logic [511:0] exp_line(input logic [17:0] a);
    logic [511:0] l;
    logic [17:0]  x, off;
    int o;
    for (int k = 0; k < 64; k++) begin
      x = a + 18'(k);
      l[8*k +: 8] = x[7:0];
      foreach (wq[i]) begin
        off = x - wq[i].a;
        o   = int'(off);
        if (o < 64 && wq[i].m[o]) l[8*k +: 8] = wq[i].d[8*o +: 8];
      end
    end
    return l;
  endfunction

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Results of the last do_req call.
  logic         r_ok, r_err, r_wait_we, r_after_valid, r_after_ready;
  logic [511:0] r_rdata;
  logic [17:0]  r_gap_addr;
  logic [63:0]  r_wait_mask;
  int           r_lat;

  task automatic do_req(input logic we, input logic [17:0] a, input logic [63:0] m,
                        input logic [511:0] d);
    int  n;
    int  entry;
    bit  seen_wait;
    r_ok = 1'b0;
    r_lat = -1;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) return;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_mask  = m;
    bus.req_wdata = d;
    @(negedge clk);
    bus.req_valid = 1'b0;
    r_gap_addr = bus.mem_addr;
    seen_wait  = 1'b0;
    entry      = 0;
    for (int i = 1; i < 400; i++) begin
      if (!seen_wait && bus.mem_addr == a) begin
        seen_wait   = 1'b1;
        entry       = i;
        r_wait_we   = bus.mem_we;
        r_wait_mask = bus.mem_mask;
      end
      if (bus.rsp_valid) begin
        r_ok    = 1'b1;
        r_err   = bus.rsp_err;
        r_rdata = bus.rsp_rdata;
        r_lat   = i - entry;
        break;
      end
      @(negedge clk);
    end
    if (r_ok) begin
      @(negedge clk);
      r_after_valid = bus.rsp_valid;
      r_after_ready = bus.req_ready;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [511:0] last_rd;
    logic [511:0] exp;
    logic [511:0] d;
    logic [17:0]  a;
    logic [63:0]  m;
    logic         we;
    logic [7:0]   b;
    logic [17:0]  pool [6];
    int           n;

    pool[0] = 18'h00040; pool[1] = 18'h00100; pool[2] = 18'h00200;
    pool[3] = 18'h3FFC0; pool[4] = 18'h3FFF0; pool[5] = 18'h01234;

    reset = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_mask = '0; bus.req_wdata = '0; bus.mem_init_done = 1'b0;

    // 1. reset values, INIT hold, then init-done release
    repeat (3) @(negedge clk);
    check("rst_req_ready", 512'(bus.req_ready), 512'(0));
    check("rst_rsp_valid", 512'(bus.rsp_valid), 512'(0));
    check("rst_busy",      512'(bus.busy),      512'(1));
    check("rst_mem_we",    512'(bus.mem_we),    512'(0));
    check("rst_mem_addr",  512'(bus.mem_addr),  512'(0));
    check("rst_mem_mask",  512'(bus.mem_mask),  512'(0));
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("init_req_ready_low", 512'(bus.req_ready), 512'(0));
    end
    bus.mem_init_done = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 2) begin
      @(negedge clk);
      n++;
    end
    check("init_ready_within_2", 512'(bus.req_ready), 512'(1));
    check("idle_busy", 512'(bus.busy), 512'(0));

    // 2. read 0x00040
    do_req(1'b0, 18'h00040, '0, '0);
    check("rd40_ok", 512'(r_ok), 512'(1));
    check("rd40_err", 512'(r_err), 512'(0));
    for (int k = 0; k < 64; k++) exp[8*k +: 8] = 8'h40 + 8'(k);
    check("rd40_data", r_rdata, exp);
    check("rd40_strobe_1cyc", 512'(r_after_valid), 512'(0));
    check("rd40_ready_after", 512'(r_after_ready), 512'(1));
    last_rd = r_rdata;

    // 3. masked write then read back
    d = {64{8'hA5}};
    do_req(1'b1, 18'h00100, 64'hFF, d);
    check("wr100_ok", 512'(r_ok), 512'(1));
    check("wr100_err", 512'(r_err), 512'(0));
    check("wr100_wait_we", 512'(r_wait_we), 512'(1));
    check("wr100_wait_mask", 512'(r_wait_mask), 512'(64'hFF));
    check("wr100_rdata_kept", r_rdata, last_rd);
    if (r_ok && !r_err) wq.push_back('{a: 18'h00100, m: 64'hFF, d: d});
    do_req(1'b0, 18'h00100, '0, '0);
    check("rd100_err", 512'(r_err), 512'(0));
    b = r_rdata[7:0];     check("rd100_b0",  512'(b), 512'(8'hA5));
    b = r_rdata[63:56];   check("rd100_b7",  512'(b), 512'(8'hA5));
    b = r_rdata[71:64];   check("rd100_b8",  512'(b), 512'(8'h08));
    b = r_rdata[511:504]; check("rd100_b63", 512'(b), 512'(8'h3F));
    check("rd100_line", r_rdata, exp_line(18'h00100));
    last_rd = r_rdata;

    // 4. back-to-back reads of the same line
    do_req(1'b0, 18'h00200, '0, '0);
    check("rd200a_gap_addr", 512'(r_gap_addr), 512'(18'h00201));
    check("rd200a_line", r_rdata, exp_line(18'h00200));
    do_req(1'b0, 18'h00200, '0, '0);
    check("rd200b_gap_addr", 512'(r_gap_addr), 512'(18'h00201));
    check("rd200b_no_stale", 512'(r_lat >= 17), 512'(1));
    check("rd200b_err", 512'(r_err), 512'(0));
    last_rd = r_rdata;

    // 5. timeout with read ready suppressed, then recovery
    kill_rdy = 1'b1;
    do_req(1'b0, 18'h00000, '0, '0);
    check("to_ok", 512'(r_ok), 512'(1));
    check("to_err", 512'(r_err), 512'(1));
    check("to_latency", 512'(r_lat), 512'(TIMEOUT));
    check("to_rdata_kept", r_rdata, last_rd);
    kill_rdy = 1'b0;
    do_req(1'b0, 18'h00000, '0, '0);
    check("to_recover_err", 512'(r_err), 512'(0));
    check("to_recover_line", r_rdata, exp_line(18'h00000));
    last_rd = r_rdata;

    // random mix of reads and masked writes against the history model
    for (int t = 0; t < 12; t++) begin
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 18'($urandom) : pool[$urandom_range(0, 5)];
      m  = {$urandom, $urandom};
      for (int k = 0; k < 16; k++) d[32*k +: 32] = $urandom;
      do_req(we, a, m, d);
      check("rnd_ok", 512'(r_ok), 512'(1));
      check("rnd_err", 512'(r_err), 512'(0));
      check("rnd_gap_addr", 512'(r_gap_addr), 512'(a ^ 18'h1));
      check("rnd_wait_we", 512'(r_wait_we), 512'(we));
      check("rnd_wait_mask", 512'(r_wait_mask), 512'(we ? m : 64'h0));
      if (we) begin
        check("rnd_wr_rdata_kept", r_rdata, last_rd);
        if (r_ok && !r_err) wq.push_back('{a: a, m: m, d: d});
      end else begin
        check("rnd_rd_line", r_rdata, exp_line(a));
        last_rd = r_rdata;
      end
    end

    // 6. asynchronous reset in the middle of a write's WAIT phase
    @(negedge clk);
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 18'h00300;
    bus.req_mask = '1; bus.req_wdata = {64{8'h5A}};
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.mem_addr != 18'h00300 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("rstw_mem_we_before", 512'(bus.mem_we), 512'(1));
    #2 reset = 1'b0;
    #1;
    check("rstw_mem_we_async", 512'(bus.mem_we), 512'(0));
    check("rstw_req_ready_async", 512'(bus.req_ready), 512'(0));
    check("rstw_rsp_valid_async", 512'(bus.rsp_valid), 512'(0));
    check("rstw_busy_async", 512'(bus.busy), 512'(1));
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstw_busy_after_release", 512'(bus.busy), 512'(1));
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) n++;
    end
    check("rstw_no_rsp", 512'(n), 512'(0));
    check("rstw_back_to_idle", 512'(bus.req_ready), 512'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
